vector_alu_tiled: RTL and testbench

Element-wise signed vector ALU and successor to the plain tiled vector adder. It processes TILING lanes per cycle with a start/finish handshake and supports add, subtract, max and min, with optional saturation. Operands are captured at start, and VECTOR_SIZE need not be a multiple of TILING. It sits in the backpropagation datapath for error and weight-update vector arithmetic.

---
 rtl/vector_alu_tiled.sv | 153 +++++++++++++++
 tb/tb_vector_alu_tiled.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_alu_tiled.sv
// Element-wise signed vector ALU (add/sub/max/min with optional saturation).
// Writes TILING lanes per cycle after a start request and pulses finish when the vector is done.
module vector_alu_tiled #(
    parameter int VECTOR_SIZE = 5,
    parameter int CELL_WIDTH  = 8,
    parameter int TILING      = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [1:0]                           op,
    input  logic                                 sat,
    input  logic [VECTOR_SIZE*CELL_WIDTH-1:0]     a,
    input  logic [VECTOR_SIZE*CELL_WIDTH-1:0]     b,
    output logic [VECTOR_SIZE*(CELL_WIDTH+1)-1:0] result,
    output logic                                 busy,
    output logic                                 finish
);

    localparam int RW = CELL_WIDTH + 1;
    localparam int CW = $clog2(VECTOR_SIZE + TILING + 1);

    localparam logic signed [RW-1:0] SAT_MAX = {2'b00, {(CELL_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {2'b11, {(CELL_WIDTH-1){1'b0}}};

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MAX = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                            state_q, state_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic [VECTOR_SIZE*CELL_WIDTH-1:0] a_q, a_d;
    logic [VECTOR_SIZE*CELL_WIDTH-1:0] b_q, b_d;
    logic [1:0]                        op_q, op_d;
    logic                              sat_q, sat_d;
    logic                              finish_q, finish_d;
    logic [VECTOR_SIZE*RW-1:0]         result_q, result_d;

    logic [RW-1:0]          lane_res [VECTOR_SIZE];
    logic [VECTOR_SIZE-1:0] lane_we;
    logic [CW-1:0]          tile_end;
    logic                   last_tile;

    assign tile_end  = cnt_q + CW'(TILING);
    assign last_tile = (tile_end >= CW'(VECTOR_SIZE));

    // Every lane has its own datapath on the latched operands; only the
    // lanes inside the current tile window are committed to result.
    generate
        for (genvar gi = 0; gi < VECTOR_SIZE; gi++) begin : g_lane
            logic signed [RW-1:0] ae, be, sum, diff, raw, clamped;

            assign ae   = {a_q[gi*CELL_WIDTH + CELL_WIDTH-1], a_q[gi*CELL_WIDTH +: CELL_WIDTH]};
            assign be   = {b_q[gi*CELL_WIDTH + CELL_WIDTH-1], b_q[gi*CELL_WIDTH +: CELL_WIDTH]};
            assign sum  = ae + be;
            assign diff = ae - be;

            always_comb begin
                raw = sum;
                case (op_q)
                    OP_ADD:  raw = sum;
                    OP_SUB:  raw = diff;
                    OP_MAX:  raw = (ae > be) ? ae : be;
                    default: raw = (ae < be) ? ae : be;
                endcase
            end

            always_comb begin
                clamped = raw;
                if (sat_q && (raw > SAT_MAX)) begin
                    clamped = SAT_MAX;
                end else if (sat_q && (raw < SAT_MIN)) begin
                    clamped = SAT_MIN;
                end
            end

            assign lane_res[gi] = clamped;
            assign lane_we[gi]  = (state_q == RUN) &&
                                  (CW'(gi) >= cnt_q) &&
                                  (CW'(gi) < tile_end);
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        sat_d    = sat_q;
        finish_d = 1'b0;
        result_d = result_q;

        for (int i = 0; i < VECTOR_SIZE; i++) begin
            if (lane_we[i]) begin
                result_d[i*RW +: RW] = lane_res[i];
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    sat_d   = sat;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = tile_end;
                if (last_tile) begin
                    state_d  = IDLE;
                    finish_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            sat_q    <= 1'b0;
            finish_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            sat_q    <= sat_d;
            finish_q <= finish_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == RUN);
    assign finish = finish_q;

endmodule

// File: tb/tb_vector_alu_tiled.sv
// Directed bench for vector_alu_tiled: four instances (TILING 2,1,3,5) share operands,
// and a scoreboard queue holds the golden vector for each launched operation.
module tb_vector_alu_tiled;

    localparam int VS = 5;
    localparam int CW = 8;
    localparam int RW = 9;
    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [1:0]        op;
    logic              sat;
    logic [VS*CW-1:0]  a, b;
    logic              start_v [NI];
    logic [VS*RW-1:0]  res_v   [NI];
    logic              busy_v  [NI];
    logic              fin_v   [NI];

    int n_cmp = 0;
    int n_mis = 0;
    logic [VS*RW-1:0] exp_q [$];
    logic [VS*RW-1:0] last_exp;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int TIL = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 3 : 5;
            vector_alu_tiled #(
                .VECTOR_SIZE(VS),
                .CELL_WIDTH (CW),
                .TILING     (TIL)
            ) u_dut (
                .clk   (clk),
                .rst   (rst),
                .start (start_v[gi]),
                .op    (op),
                .sat   (sat),
                .a     (a),
                .b     (b),
                .result(res_v[gi]),
                .busy  (busy_v[gi]),
                .finish(fin_v[gi])
            );
        end
    endgenerate

    function automatic int tiles(input int k);
        int til;
        til = (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 3 : 5;
        return (VS + til - 1) / til;
    endfunction

    function automatic logic [VS*CW-1:0] pack5(input int e0, e1, e2, e3, e4);
        int e [VS];
        logic [VS*CW-1:0] p;
        e = '{e0, e1, e2, e3, e4};
        p = '0;
        for (int i = 0; i < VS; i++) p[i*CW +: CW] = CW'(e[i]);
        return p;
    endfunction

    function automatic logic [VS*RW-1:0] pack9(input int e0, e1, e2, e3, e4);
        int e [VS];
        logic [VS*RW-1:0] p;
        e = '{e0, e1, e2, e3, e4};
        p = '0;
        for (int i = 0; i < VS; i++) p[i*RW +: RW] = RW'(e[i]);
        return p;
    endfunction

    function automatic logic [VS*RW-1:0] model(input logic [1:0] o, input logic s,
                                               input logic [VS*CW-1:0] av, input logic [VS*CW-1:0] bv);
        logic [VS*RW-1:0] r;
        r = '0;
        for (int i = 0; i < VS; i++) begin
            int x, y, z;
            x = $signed(av[i*CW +: CW]);
            y = $signed(bv[i*CW +: CW]);
            case (o)
                2'd0:    z = x + y;
                2'd1:    z = x - y;
                2'd2:    z = (x > y) ? x : y;
                default: z = (x < y) ? x : y;
            endcase
            if (s) begin
                if (z > 127)  z = 127;
                if (z < -128) z = -128;
            end
            r[i*RW +: RW] = RW'(z);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called just after a falling edge; returns one falling edge after the start edge.
    task automatic launch(input int k, input logic [1:0] o, input logic s,
                          input logic [VS*CW-1:0] av, input logic [VS*CW-1:0] bv);
        op         = o;
        sat        = s;
        a          = av;
        b          = bv;
        start_v[k] = 1'b1;
        exp_q.push_back(model(o, s, av, bv));
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    // first_cyc = number of falling edges already passed since the start edge.
    task automatic await_done(input int k, input string tag, input int first_cyc);
        int  cyc;
        int  busy_cycles;
        bit  seen;
        logic [VS*RW-1:0] expv;
        cyc         = first_cyc;
        busy_cycles = first_cyc - 1;
        seen        = 1'b0;
        while (cyc <= 20) begin
            if (fin_v[k]) begin
                seen = 1'b1;
                break;
            end
            if (busy_v[k]) busy_cycles++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " finish_seen"}, 64'(seen), 64'd1);
        expv = exp_q.pop_front();
        last_exp = expv;
        if (seen) begin
            check({tag, " latency"}, 64'(cyc - 1), 64'(tiles(k)));
            check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(tiles(k)));
            check({tag, " busy_at_finish"}, 64'(busy_v[k]), 64'd0);
            check({tag, " result"}, 64'(res_v[k]), 64'(expv));
            $display("op %-12s inst=%0d T=%0d latency=%0d result=%h expected=%h",
                     tag, k, tiles(k), cyc - 1, res_v[k], expv);
        end
    endtask

    initial begin
        logic [VS*CW-1:0] va, vb, vmm_a, vmm_b;
        int nfin;

        rst = 1'b1;
        op  = '0;
        sat = 1'b0;
        a   = '0;
        b   = '0;
        for (int k = 0; k < NI; k++) start_v[k] = 1'b0;
        repeat (3) @(negedge clk);
        check("reset result", 64'(res_v[0]), 64'd0);
        check("reset busy", 64'(busy_v[0]), 64'd0);
        check("reset finish", 64'(fin_v[0]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        va = pack5(1, 2, 3, 4, 5);
        vb = pack5(10, 20, 30, 40, 50);

        // ADD, TILING=2
        launch(0, 2'd0, 1'b0, va, vb);
        await_done(0, "add", 1);
        check("add spec_vector", 64'(res_v[0]), 64'(pack9(11, 22, 33, 44, 55)));
        @(negedge clk);
        check("add finish_one_cycle", 64'(fin_v[0]), 64'd0);
        check("add result_held", 64'(res_v[0]), 64'(last_exp));

        // SUB overflow without and with saturation, ADD saturation
        launch(0, 2'd1, 1'b0, pack5(-128, 5, -1, 100, 0), pack5(127, 9, 1, -100, 0));
        await_done(0, "sub_wrap", 1);
        check("sub_wrap elem0", 64'(res_v[0][8:0]), 64'h101);
        launch(0, 2'd1, 1'b1, pack5(-128, 5, -1, 100, 0), pack5(127, 9, 1, -100, 0));
        await_done(0, "sub_sat", 1);
        check("sub_sat elem0", 64'(res_v[0][8:0]), 64'h180);
        launch(0, 2'd0, 1'b1, pack5(127, -128, 1, 2, 3), pack5(127, -128, 1, 2, 3));
        await_done(0, "add_sat", 1);
        check("add_sat elem0", 64'(res_v[0][8:0]), 64'h07F);
        check("add_sat elem1", 64'(res_v[0][17:9]), 64'h180);

        // MAX / MIN
        vmm_a = pack5(-5, 7, 0, -128, 127);
        vmm_b = pack5(3, -7, 0, -127, 126);
        launch(0, 2'd2, 1'b0, vmm_a, vmm_b);
        await_done(0, "max", 1);
        check("max spec_vector", 64'(res_v[0]), 64'(pack9(3, 7, 0, -127, 127)));
        launch(0, 2'd3, 1'b0, vmm_a, vmm_b);
        await_done(0, "min", 1);
        check("min spec_vector", 64'(res_v[0]), 64'(pack9(-5, -7, 0, -128, 126)));

        // Isolation: operands and start change while running
        launch(0, 2'd0, 1'b0, va, vb);
        a          = '0;
        b          = '0;
        op         = 2'd1;
        sat        = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        await_done(0, "isolation", 2);
        nfin = 0;
        repeat (6) begin
            @(negedge clk);
            if (fin_v[0]) nfin++;
        end
        check("isolation extra_finish", 64'(nfin), 64'd0);
        check("isolation idle", 64'(busy_v[0]), 64'd0);

        // Reset one cycle after the start edge
        launch(0, 2'd0, 1'b0, va, vb);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("rst_mid result", 64'(res_v[0]), 64'd0);
        check("rst_mid busy", 64'(busy_v[0]), 64'd0);
        nfin = 0;
        repeat (5) begin
            @(negedge clk);
            if (fin_v[0]) nfin++;
        end
        check("rst_mid finish_count", 64'(nfin), 64'd0);
        launch(0, 2'd1, 1'b0, vb, va);
        await_done(0, "after_rst", 1);

        // Tiling sweep with the ADD case, then back-to-back starts on every instance
        for (int k = 1; k < NI; k++) begin
            launch(k, 2'd0, 1'b0, va, vb);
            await_done(k, "sweep_add", 1);
            check("sweep_add spec_vector", 64'(res_v[k]), 64'(pack9(11, 22, 33, 44, 55)));
        end
        for (int k = 0; k < NI; k++) begin
            @(negedge clk);
            launch(k, 2'd0, 1'b0, va, vb);
            await_done(k, "b2b_first", 1);
            launch(k, 2'd3, 1'b1, vmm_a, vmm_b);
            await_done(k, "b2b_second", 1);
        end

        // A few random operations on the partial-tile instance
        repeat (4) begin
            @(negedge clk);
            launch(2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   {$urandom, 8'($urandom)}, {$urandom, 8'($urandom)});
            await_done(2, "random", 1);
        end

        check("scoreboard empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
